song_sequencer: RTL



---
 rtl/synth_pkg.sv | 54 +++++
 rtl/song_table.sv | 38 +++
 rtl/song_sequencer.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/synth_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : synth_pkg
//  Description : Shared types and constants for the song sequencer. Holds the
//                just-intonation ratio table (Q12.20), the packed song-entry
//                layout and the sequencer state encoding.
//  Revision    : 1.0  initial release
// ============================================================================
package synth_pkg;

    localparam int FRAC_BITS  = 20;
    localparam int NUM_RATIOS = 13;
    localparam logic [3:0] MAX_NOTE = 4'd12;

    // floor((num << 20) / den) for the chromatic just-intonation scale,
    // index 0 = unison up to index 12 = octave.
    localparam logic [31:0] RATIO_Q20 [NUM_RATIOS] = '{
        32'd1048576,   // 1/1
        32'd1118481,   // 16/15
        32'd1179648,   // 9/8
        32'd1258291,   // 6/5
        32'd1310720,   // 5/4
        32'd1398101,   // 4/3
        32'd1474560,   // 45/32
        32'd1572864,   // 3/2
        32'd1677721,   // 8/5
        32'd1747626,   // 5/3
        32'd1864135,   // 16/9
        32'd1966080,   // 15/8
        32'd2097152    // 2/1
    };

    // Matches the 11-bit write word {len[10:7], cutoff[6:4], note[3:0]}.
    typedef struct packed {
        logic [3:0] len;
        logic [2:0] cutoff;
        logic [3:0] note;
    } song_entry_t;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_CALC = 3'd2,
        ST_PLAY = 3'd3,
        ST_DONE = 3'd4
    } seq_state_t;

    // Indices above the octave are pinned to the octave.
    function automatic logic [3:0] clamp_note(input logic [3:0] note);
        return (note > MAX_NOTE) ? MAX_NOTE : note;
    endfunction

endpackage
`default_nettype wire

// File: rtl/song_table.sv
`default_nettype none
// ============================================================================
//  Module      : song_table
//  Description : SONG_DEPTH x 11 song RAM, one write port, registered read.
//                Contents have no reset.
//  Ports       : clk        system clock
//                wr_en_i    write strobe
//                wr_addr_i  write address
//                wr_data_i  entry to store
//                rd_addr_i  read address
//                rd_data_o  entry at rd_addr_i, one cycle later
//  Revision    : 1.0  initial release
// ============================================================================
module song_table
    import synth_pkg::*;
#(
    parameter int SONG_DEPTH = 16,
    parameter int ADDR_W     = $clog2(SONG_DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  song_entry_t       wr_data_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output song_entry_t       rd_data_o
);

    song_entry_t mem_q [SONG_DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        rd_data_o <= mem_q[rd_addr_i];
    end

endmodule
`default_nettype wire

// File: rtl/song_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : song_sequencer
//  Description : Plays the on-chip song table into the 8-voice synthesizer:
//                per step converts the note index into Q12.20 voice
//                frequencies, drives volumes and cutoff, and holds them for
//                len * SAMPLES_PER_HALF sample ticks.
//  Config      : SONG_SEQUENCER_LOOP_EN - when defined, the end of the song
//                restarts at entry 0 instead of entering DONE.
//  Ports       : clk, reset_n          clock, async active-low reset
//                sample_tick           one pulse per output sample
//                start / stop          playback control pulses
//                wr_en/wr_addr/wr_data song table write (IDLE/DONE only)
//                frequencies           per-voice frequency, Q12.20
//                voice_volumes         per-voice volume
//                cutoff                filter cutoff
//                busy / done           status
//                note_strobe           pulse when new note outputs are valid
//  Revision    : 1.0  initial release
// ============================================================================
module song_sequencer
    import synth_pkg::*;
#(
    parameter int          NUM_VOICES       = 8,
    parameter int          SONG_DEPTH       = 16,
    parameter int          SAMPLES_PER_HALF = 6000,
    parameter logic [31:0] BASE_FREQ_Q20    = 32'd110 << 20,
    parameter logic [31:0] VOICE_VOLUME     = 32'd1 << 20
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         sample_tick,
    input  logic                         start,
    input  logic                         stop,
    input  logic                         wr_en,
    input  logic [$clog2(SONG_DEPTH)-1:0] wr_addr,
    input  logic [10:0]                  wr_data,
    output logic [NUM_VOICES-1:0][31:0]  frequencies,
    output logic [NUM_VOICES-1:0][31:0]  voice_volumes,
    output logic [2:0]                   cutoff,
    output logic                         busy,
    output logic                         note_strobe,
    output logic                         done
);

    localparam int ADDR_W = $clog2(SONG_DEPTH);
    localparam int CNT_W  = $clog2(15 * SAMPLES_PER_HALF) + 1;

    seq_state_t         state_q,   state_d;
    logic [ADDR_W-1:0]  addr_q,    addr_d;
    logic [CNT_W-1:0]   cnt_q,     cnt_d;
    logic [3:0]         len_q,     len_d;
    logic [31:0]        product_q, product_d;
    logic [2:0]         cutoff_q,  cutoff_d;
    logic               vol_on_q,  vol_on_d;
    logic               strobe_q,  strobe_d;

    song_entry_t        w_entry;
    logic [63:0]        w_mult;
    logic [31:0]        w_prod;
    logic [CNT_W-1:0]   w_limit;

    assign busy = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign done = (state_q == ST_DONE);

    song_table #(
        .SONG_DEPTH (SONG_DEPTH),
        .ADDR_W     (ADDR_W)
    ) u_table (
        .clk       (clk),
        .wr_en_i   (wr_en && !busy),
        .wr_addr_i (wr_addr),
        .wr_data_i (song_entry_t'(wr_data)),
        .rd_addr_i (addr_q),
        .rd_data_o (w_entry)
    );

    assign w_mult  = 64'(BASE_FREQ_Q20) * 64'(RATIO_Q20[clamp_note(w_entry.note)]);
    assign w_prod  = 32'(w_mult >> FRAC_BITS);
    assign w_limit = CNT_W'(len_q) * CNT_W'(SAMPLES_PER_HALF) - CNT_W'(1);

    // Frequencies are a pure function of the product register, so they hold
    // through the LOAD/CALC gap and after stop/DONE without extra storage.
    generate
        for (genvar i = 0; i < NUM_VOICES; i++) begin : g_voice
            assign frequencies[i]   = product_q << (i % 3);
            assign voice_volumes[i] = vol_on_q ? VOICE_VOLUME : 32'd0;
        end
    endgenerate

    assign cutoff      = cutoff_q;
    assign note_strobe = strobe_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            cnt_q     <= '0;
            len_q     <= '0;
            product_q <= '0;
            cutoff_q  <= '0;
            vol_on_q  <= 1'b0;
            strobe_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            cnt_q     <= cnt_d;
            len_q     <= len_d;
            product_q <= product_d;
            cutoff_q  <= cutoff_d;
            vol_on_q  <= vol_on_d;
            strobe_q  <= strobe_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        len_d     = len_q;
        product_d = product_q;
        cutoff_d  = cutoff_q;
        vol_on_d  = vol_on_q;
        strobe_d  = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_LOAD;
                    addr_d  = '0;
                end
            end
            ST_LOAD: begin
                // Table read address is addr_q; data lands in CALC.
                state_d = ST_CALC;
            end
            ST_CALC: begin
                if (w_entry.len == 4'd0) begin
`ifdef SONG_SEQUENCER_LOOP_EN
                    state_d = ST_LOAD;
                    addr_d  = '0;
`else
                    state_d  = ST_DONE;
                    vol_on_d = 1'b0;
`endif
                end else begin
                    state_d   = ST_PLAY;
                    product_d = w_prod;
                    len_d     = w_entry.len;
                    cutoff_d  = w_entry.cutoff;
                    vol_on_d  = 1'b1;
                    strobe_d  = 1'b1;
                    cnt_d     = '0;
                end
            end
            ST_PLAY: begin
                if (sample_tick) begin
                    if (cnt_q == w_limit) begin
                        if (addr_q != ADDR_W'(SONG_DEPTH - 1)) begin
                            addr_d  = addr_q + ADDR_W'(1);
                            state_d = ST_LOAD;
                        end else begin
`ifdef SONG_SEQUENCER_LOOP_EN
                            addr_d  = '0;
                            state_d = ST_LOAD;
`else
                            state_d  = ST_DONE;
                            vol_on_d = 1'b0;
`endif
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abort has priority over everything, including a coincident start.
        if (stop) begin
            state_d  = ST_IDLE;
            addr_d   = '0;
            vol_on_d = 1'b0;
            strobe_d = 1'b0;
        end
    end

endmodule
`default_nettype wire
